mac_out_writer: RTL
===================

MAC_OUT_WRITER -- requirements
Module: mac_out_writer

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 1024, meaning output pixels per frame (32x32).
REQ-002 SHALL have parameter OUT_GROUPS, default 5, meaning 16-channel groups per pixel (80 output channels).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning result words buffered; power of two.
REQ-004 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port MAC_out_valid  input  1  MAC result word present this cycle; no backpressure to the MAC.
REQ-007 SHALL have port MAC_data_out  input  128  16 signed 8-bit channel results; byte q = channel q of the current group.
REQ-008 SHALL have port frame_clr  input  1  synchronous clear of counters, FIFO and overflow flag.
REQ-009 SHALL have port wr_ready  input  1  output buffer accepts a word.
REQ-010 SHALL have port wr_valid  output  1  wr_addr/wr_data valid.
REQ-011 SHALL have port wr_addr  output  16  output-buffer word address.
REQ-012 SHALL have port wr_data  output  128  result word written.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the frame's last word is written.
REQ-014 SHALL have port overflow  output  1  sticky flag; a result word was dropped.

Function
REQ-015 SHALL push {MAC_data_out} into the FIFO in the cycle MAC_out_valid=1 and the FIFO is not full, or is full with a pop in the same cycle.
REQ-016 SHALL drop the word and set overflow when MAC_out_valid=1, FIFO full and no pop occurs in that cycle; the address counters SHALL still advance.
REQ-017 SHALL tag each accepted word with addr = grp*IMG_PIXELS + pix; grp and pix are arrival counters, grp incrementing per MAC_out_valid, wrapping at OUT_GROUPS-1 and then incrementing pix.
REQ-018 SHALL wrap pix to 0 after IMG_PIXELS-1 with grp=OUT_GROUPS-1, so the next frame starts at address 0 without frame_clr.
REQ-019 SHALL assert wr_valid whenever the FIFO is non-empty, presenting the head word; a word pushed into an empty FIFO SHALL appear on wr_valid in the next cycle (1-cycle latency).
REQ-020 SHALL pop the FIFO on wr_valid & wr_ready; wr_addr/wr_data SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-021 SHALL pulse frame_done for exactly one cycle, in the cycle after the handshake of the word whose address is (OUT_GROUPS-1)*IMG_PIXELS + IMG_PIXELS-1.
REQ-022 SHALL give frame_clr priority over a simultaneous push or pop; the word in that cycle is discarded and the next accepted word gets address 0.
REQ-023 SHALL support simultaneous push and pop on an empty FIFO with no bypass: the pushed word appears in the next cycle.

Reset
REQ-024 SHALL, while rstn=0, hold wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, overflow=0, FIFO empty, grp=0, pix=0.
REQ-025 SHALL discard buffered words and restart addressing at 0 when reset asserts mid-frame.

Configuration
REQ-026 SHALL, when macro MAC_OUT_RELU_EN is defined, replace each negative signed byte of MAC_data_out with 0x00 before the FIFO; otherwise bytes SHALL be stored unmodified.

Verification
REQ-027 SHALL cover: single MAC_out_valid with 0x0F..0x00 bytes, wr_ready=1 -> wr_valid one cycle later, wr_addr=0, data unchanged.
REQ-028 SHALL cover: 5 valids at 1-in-4 cadence (pix 0, grp 0..4) -> wr_addr 0,1024,2048,3072,4096 in order.
REQ-029 SHALL cover: wr_ready=0 with 5 valids -> 4 words buffered, overflow=1, 5th dropped; after wr_ready=1 addresses 0,1024,2048,3072 in order.
REQ-030 SHALL cover: full frame of 5120 valids, wr_ready=1 -> last wr_addr=5119, frame_done one pulse, next word at address 0.
REQ-031 SHALL cover: byte 0x80 input -> 0x00 out with MAC_OUT_RELU_EN, 0x80 out without.
REQ-032 SHALL cover: rstn low after 7 words with 2 buffered -> wr_valid=0 immediately, next word at address 0.

Source files
------------

// File: rtl/mac_out_writer.sv
// mac_out_writer
// Buffers 128-bit MAC result words in a small FIFO, tags each word with its
// output-buffer address (grp*IMG_PIXELS + pix) and hands it to the output
// buffer over a valid/ready handshake. The MAC cannot be stalled: a word that
// finds the FIFO full is dropped and the sticky overflow flag is raised.
//
// Optional build feature:
//   MAC_OUT_RELU_EN - when defined, every negative signed byte of the incoming
//                     result word is replaced by 0x00 before it is buffered.
module mac_out_writer #(
  parameter int IMG_PIXELS = 1024,  // output pixels per frame
  parameter int OUT_GROUPS = 5,     // 16-channel groups per pixel
  parameter int FIFO_DEPTH = 4      // buffered result words, power of two
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         MAC_out_valid,
  input  logic [127:0] MAC_data_out,
  input  logic         frame_clr,
  input  logic         wr_ready,
  output logic         wr_valid,
  output logic [15:0]  wr_addr,
  output logic [127:0] wr_data,
  output logic         frame_done,
  output logic         overflow
);

  localparam int GRP_W = (OUT_GROUPS > 1) ? $clog2(OUT_GROUPS) : 1;
  localparam int PIX_W = (IMG_PIXELS > 1) ? $clog2(IMG_PIXELS) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [GRP_W-1:0] GRP_LAST  = GRP_W'(OUT_GROUPS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(IMG_PIXELS - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      LAST_ADDR = 16'(OUT_GROUPS * IMG_PIXELS - 1);

  // One buffered result: the address it was tagged with on arrival and its data.
  typedef struct packed {
    logic [15:0]  addr;
    logic [127:0] data;
  } entry_t;

  // Arrival counters
  logic [GRP_W-1:0] grp_q;
  logic [PIX_W-1:0] pix_q;
  logic [15:0]      cur_addr;

  // FIFO state
  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  entry_t           head;
  entry_t           push_entry;
  logic [127:0]     push_data;

  // Per-cycle control
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic drop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Address of the word arriving this cycle, from the group/pixel counters.
  assign cur_addr = 16'(grp_q) * 16'(IMG_PIXELS) + 16'(pix_q);

  // Handshake decode: frame_clr overrides both sides; a pop frees a slot for a
  // push in the same cycle, so a full FIFO only drops when nothing leaves.
  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no latch is inferred.
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_FULL);
    pop        = !fifo_empty && wr_ready && !frame_clr;
    push       = MAC_out_valid && !frame_clr && (!fifo_full || pop);
    drop       = MAC_out_valid && !frame_clr && fifo_full && !pop;
  end

  // Optional ReLU on the incoming word, then pack it with its address tag.
  always_comb begin
    push_data = MAC_data_out;
`ifdef MAC_OUT_RELU_EN
    for (int q = 0; q < 16; q++) begin
      if (MAC_data_out[8*q+7]) begin
        push_data[8*q +: 8] = 8'h00;
      end
    end
`endif
    push_entry.addr = cur_addr;
    push_entry.data = push_data;
  end

  // Arrival counters: grp steps on every MAC word (kept or dropped), pix steps
  // when grp wraps, and the pair wraps at frame end so frames run back to back.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      grp_q <= '0;
      pix_q <= '0;
    end else if (frame_clr) begin
      grp_q <= '0;
      pix_q <= '0;
    end else if (MAC_out_valid) begin
      if (grp_q == GRP_LAST) begin
        grp_q <= '0;
        pix_q <= (pix_q == PIX_LAST) ? '0 : pix_q + 1'b1;
      end else begin
        grp_q <= grp_q + 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (frame_clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage has no reset; an entry is only visible once count_q covers it, and the outputs are gated to zero while empty.
    if (push) begin
      mem[wr_ptr_q] <= push_entry;
    end
  end

  // Head of the FIFO drives the output buffer; zero while empty so reset and
  // idle both present a clean bus.
  assign head     = mem[rd_ptr_q];
  assign wr_valid = !fifo_empty;
  assign wr_addr  = wr_valid ? head.addr : '0;
  assign wr_data  = wr_valid ? head.data : '0;

  // Status: sticky overflow on a dropped word; frame_done follows the
  // handshake of the frame's final address by one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_clr) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      frame_done <= pop && (head.addr == LAST_ADDR);
    end
  end

endmodule
